// File: rtl/data_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port data memory between two Avalon-MM masters,
//           with bounded lock for atomic RMW, out-of-range protection and a sticky error flag.
// Latency : grant is combinational from registered state; read data returns exactly 1 cycle after acceptance.
// Backpressure: a master that is not granted (or idle) sees waitrequest=1; a lock owner holds the memory
//           for at most LOCK_MAX consecutive grants before the round-robin pointer decides.
// Ports   : clk/reset_n; per master mN_address/read/write/byteenable/writedata/lock in,
//           mN_waitrequest/readdata/readdatavalid out; mem_* drive the memory slave port,
//           mem_readdata returns from it; err_oor is the sticky out-of-range flag.
module data_mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 342,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oor
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  // One extra bit so DEPTH == 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W + 1)'(DEPTH);

  logic             prio_q, prio_d;
  logic             lock_vld_q, lock_vld_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_owner_q, rd_owner_d;
  logic             rd_oor_q, rd_oor_d;
  logic             err_q, err_d;

  logic m0_req, m1_req, owner_req, lock_hit, gnt_vld, gnt_sel, sel_m1;
  logic [ADDR_W-1:0] g_addr;
  logic g_read, g_write, g_lock, g_oor;

  assign m0_req    = m0_read | m0_write;
  assign m1_req    = m1_read | m1_write;
  assign owner_req = lock_owner_q ? m1_req : m0_req;
  assign lock_hit  = lock_vld_q & owner_req & (lock_cnt_q < LOCK_MAX_C);
  // Holding reset_n in the grant keeps both waitrequests high throughout reset.
  assign gnt_vld   = reset_n & (m0_req | m1_req);
  assign gnt_sel   = lock_hit ? lock_owner_q : ((m0_req & m1_req) ? prio_q : m1_req);
  // With no grant the memory bus shows master-0 values.
  assign sel_m1    = gnt_vld & gnt_sel;

  assign g_addr  = sel_m1 ? m1_address : m0_address;
  assign g_read  = sel_m1 ? m1_read    : m0_read;
  assign g_write = sel_m1 ? m1_write   : m0_write;
  assign g_lock  = sel_m1 ? m1_lock    : m0_lock;
  assign g_oor   = {1'b0, g_addr} >= DEPTH_C;

  assign mem_address    = g_addr;
  assign mem_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel_m1 ? m1_writedata  : m0_writedata;
  // An out-of-range write is swallowed entirely; an out-of-range read still strobes
  // the memory but its data is replaced by zero on return.
  assign mem_chipselect = gnt_vld & ~(g_write & g_oor);
  assign mem_write      = gnt_vld & g_write & ~g_oor;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = ~(gnt_vld & ~gnt_sel);
  assign m1_waitrequest = ~(gnt_vld &  gnt_sel);

  assign m0_readdatavalid = rd_vld_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_vld_q &  rd_owner_q;
  assign m0_readdata      = rd_oor_q ? '0 : mem_readdata;
  assign m1_readdata      = rd_oor_q ? '0 : mem_readdata;
  assign err_oor          = err_q;

  always_comb begin
    prio_d       = prio_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    rd_vld_d     = 1'b0;
    rd_owner_d   = rd_owner_q;
    rd_oor_d     = rd_oor_q;
    err_d        = err_q;

    // Owner dropping its request gives the lock up; an acceptance below overrides this.
    if (lock_vld_q && !owner_req) begin
      lock_vld_d = 1'b0;
      lock_cnt_d = '0;
    end

    if (gnt_vld) begin
      prio_d = ~gnt_sel;
      if (g_lock) begin
        lock_vld_d   = 1'b1;
        lock_owner_d = gnt_sel;
        if (lock_vld_q && (lock_owner_q == gnt_sel)) begin
          // Saturate: any count >= LOCK_MAX behaves identically in arbitration.
          lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
        end else begin
          lock_cnt_d = CNT_W'(1);
        end
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
      end
      if (g_read) begin
        rd_vld_d   = 1'b1;
        rd_owner_d = gnt_sel;
        rd_oor_d   = g_oor;
      end
      if (g_oor) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q       <= 1'b0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oor_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      err_q        <= err_d;
    end
  end

endmodule
